// File: rtl/adder_accumulator_console_if.sv
// Console bus: raw buttons, operand switches and display select toward the
// accumulator; display value and status flags back toward the digit driver.
interface adder_accumulator_console_if #(
  parameter int WIDTH = 8
);
  logic             btn_load;
  logic             btn_add;
  logic             btn_sub;
  logic [WIDTH-1:0] data_in;
  logic [1:0]       output_sel;
  logic [WIDTH-1:0] data_out;
  logic             carry;
  logic             overflow;

  // Board / stimulus side
  modport master (
    output btn_load, btn_add, btn_sub, data_in, output_sel,
    input  data_out, carry, overflow
  );

  // Accumulator side
  modport slave (
    input  btn_load, btn_add, btn_sub, data_in, output_sel,
    output data_out, carry, overflow
  );
endinterface

// File: rtl/adder_accumulator_console.sv
// Push-button adder/accumulator console: per-button sync + debounce + press
// pulse, load/add/sub datapath with carry/borrow and signed overflow, last
// operand and wrapping 8-bit command counter, all muxed onto one display bus.

// One button lane: 2-flop synchroniser, counter debounce, rising-edge pulse.
module adder_accumulator_console_btn #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          deb_q, deb_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_d;

  // Debounce: a differing level must persist DEBOUNCE_CYCLES edges; any
  // sample back at the accepted level restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, debounced level and its one-cycle delay
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  // Press only; the release edge of deb is ignored
  assign pulse_o = deb_q & ~deb_dly_q;
endmodule

module adder_accumulator_console #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  adder_accumulator_console_if.slave    bus
);
  localparam int NUM_BTN = 3;
  localparam int B_LOAD  = 0;
  localparam int B_ADD   = 1;
  localparam int B_SUB   = 2;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] pulse;

  assign raw = {bus.btn_sub, bus.btn_add, bus.btn_load};

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      adder_accumulator_console_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
        .clock  (clock),
        .reset  (reset),
        .btn_i  (raw[g]),
        .pulse_o(pulse[g])
      );
    end
  endgenerate

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum, diff;
  logic             sa, sb;

  assign sa   = acc_q[WIDTH-1];
  assign sb   = bus.data_in[WIDTH-1];
  assign sum  = {1'b0, acc_q} + {1'b0, bus.data_in};
  assign diff = {1'b0, acc_q} - {1'b0, bus.data_in};

  // Command decode with load > sub > add; lower-priority pulses are dropped
  always_comb begin
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (pulse[B_LOAD]) begin
      acc_d   = bus.data_in;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (pulse[B_SUB]) begin
      acc_d   = diff[WIDTH-1:0];
      carry_d = diff[WIDTH];                       // borrow out
      ovf_d   = (sa != sb) && (diff[WIDTH-1] != sa);
    end else if (pulse[B_ADD]) begin
      acc_d   = sum[WIDTH-1:0];
      carry_d = sum[WIDTH];
      ovf_d   = (sa == sb) && (sum[WIDTH-1] != sa);
    end
    if (|pulse) begin
      opnd_d = bus.data_in;
      cnt_d  = cnt_q + 8'd1;
    end
  end

  // Datapath state
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // Display select; purely combinational over registered state
  always_comb begin
    bus.data_out = '0;
    unique case (bus.output_sel)
      2'b00: bus.data_out = acc_q;
      2'b01: bus.data_out = opnd_q;
      2'b10: bus.data_out[7:0] = cnt_q;
      default: bus.data_out[1:0] = {ovf_q, carry_q};
    endcase
  end

  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_adder_accumulator_console.sv
// Directed bench for adder_accumulator_console (WIDTH=8, DEBOUNCE_CYCLES=4):
// an independent model pushes expected state on each command, popped at the
// expected result edge and compared on every display select.
module tb_adder_accumulator_console;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  adder_accumulator_console_if #(.WIDTH(8)) bus ();

  adder_accumulator_console #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0] acc;
    logic [7:0] opnd;
    logic [7:0] cnt;
    logic       c;
    logic       v;
  } exp_t;

  exp_t m;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: mask = {sub, add, load}
  task automatic apply(input logic [2:0] mk, input logic [7:0] d);
    int ua, sa, sd, sr;
    ua = int'(m.acc);
    sa = int'($signed(m.acc));
    sd = int'($signed(d));
    if (mk[0]) begin
      m.acc = d; m.c = 1'b0; m.v = 1'b0;
    end else if (mk[2]) begin
      sr    = sa - sd;
      m.c   = (int'(d) > ua);
      m.v   = (sr > 127) || (sr < -128);
      m.acc = 8'((ua - int'(d)) & 255);
    end else if (mk[1]) begin
      sr    = sa + sd;
      m.c   = (ua + int'(d)) > 255;
      m.v   = (sr > 127) || (sr < -128);
      m.acc = 8'((ua + int'(d)) & 255);
    end
    if (|mk) begin
      m.opnd = d;
      m.cnt  = 8'((int'(m.cnt) + 1) % 256);
      exp_q.push_back(m);
    end
  endtask

  task automatic check_all(input exp_t e, input string tag);
    logic [7:0] ev;
    for (int s = 0; s < 4; s++) begin
      bus.output_sel = 2'(s);
      #1;
      case (s)
        0: ev = e.acc;
        1: ev = e.opnd;
        2: ev = e.cnt;
        default: ev = {6'b0, e.v, e.c};
      endcase
      checks++;
      assert (bus.data_out === ev) else begin
        errors++;
        $error("FAIL %s sel=%0d data_out=%h expected=%h", tag, s, bus.data_out, ev);
      end
    end
    checks++;
    assert (bus.carry === e.c) else begin
      errors++;
      $error("FAIL %s carry=%b expected=%b", tag, bus.carry, e.c);
    end
    checks++;
    assert (bus.overflow === e.v) else begin
      errors++;
      $error("FAIL %s overflow=%b expected=%b", tag, bus.overflow, e.v);
    end
  endtask

  // Called just after the edge preceding edge 0; checks no change through
  // edge 5 and the popped result after edge 6; returns 1ns after edge 7.
  task automatic settle(input exp_t pre, input string tag);
    exp_t e;
    repeat (6) @(posedge clock);
    @(negedge clock);
    check_all(pre, {tag, "_e5"});
    @(posedge clock);
    @(negedge clock);
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_all(e, {tag, "_e6"});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic release_all(input string tag);
    {bus.btn_sub, bus.btn_add, bus.btn_load} = 3'b000;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check_all(m, {tag, "_rel"});
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [2:0] mk, input logic [7:0] d, input string tag);
    exp_t pre;
    pre = m;
    apply(mk, d);
    bus.data_in = d;
    {bus.btn_sub, bus.btn_add, bus.btn_load} = mk;
    settle(pre, tag);
    release_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t pre;
    bus.btn_load = 1'b0; bus.btn_add = 1'b0; bus.btn_sub = 1'b0;
    bus.data_in = 8'h00; bus.output_sel = 2'b00;
    m = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_all(m, "reset");
    @(posedge clock); #1;

    // Load, add with carry, signed add overflow
    press(3'b001, 8'h3C, "load3c");
    press(3'b010, 8'hD0, "add_d0");
    press(3'b001, 8'h40, "load40");
    press(3'b010, 8'h50, "add50");

    // Subtract with borrow, signed subtract overflow
    press(3'b001, 8'h03, "load03");
    press(3'b100, 8'h05, "sub05");
    press(3'b001, 8'h80, "load80");
    press(3'b100, 8'h01, "sub01");

    // Bounce: 3 high, 1 low, then held; one add from the final rise
    pre = m;
    apply(3'b010, 8'h22);
    bus.data_in = 8'h22;
    bus.btn_add = 1'b1;
    repeat (3) @(posedge clock);
    #1 bus.btn_add = 1'b0;
    @(posedge clock);
    #1 bus.btn_add = 1'b1;
    settle(pre, "bounce");
    repeat (32) @(posedge clock);
    @(negedge clock);
    check_all(m, "bounce_hold");
    @(posedge clock); #1;
    release_all("bounce");

    // Coincident presses
    press(3'b011, 8'h11, "load_add");
    press(3'b110, 8'h05, "sub_add");

    // Button held through reset release is a fresh press
    reset = 1'b1;
    bus.btn_load = 1'b1;
    bus.data_in = 8'h77;
    @(posedge clock);
    #1 reset = 1'b0;
    m = '0;
    exp_q.delete();
    pre = m;
    apply(3'b001, 8'h77);
    settle(pre, "held_rst");
    release_all("held_rst");

    // Reset at edge 3 of a press discards it
    bus.data_in = 8'h55;
    bus.btn_load = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    bus.btn_load = 1'b0;
    m = '0;
    exp_q.delete();
    repeat (12) @(posedge clock);
    @(negedge clock);
    check_all(m, "rst_mid");
    @(posedge clock); #1;

    // 256 commands from reset: op_count wraps back to 0
    for (int i = 0; i < 256; i++) press(3'b001, 8'(i), "wrap");
    checks++;
    assert (m.cnt === 8'h00) else begin
      errors++;
      $error("FAIL wrap_model cnt=%h expected=00", m.cnt);
    end
    bus.output_sel = 2'b10;
    #1;
    checks++;
    assert (bus.data_out === 8'h00) else begin
      errors++;
      $error("FAIL wrap_final data_out=%h expected=00", bus.data_out);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
